stack_sequencer: RTL and testbench

- Multi-cycle sequencer for stack-based control transfers: CALL, RET, RTI, software INT and external interrupt.
- Owns the stack pointer and the single 16-bit data-memory port during these operations, and stalls the pipeline while it works.
- Splits the 32-bit PC into two 16-bit stack words, saves/restores the 3-bit flags, and issues the final PC/flags load.
- Sits beside decode; decode raises one request pulse per stack-transfer opcode.

---
 rtl/stack_sequencer_if.sv | 27 ++
 rtl/stack_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_stack_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
// Data-memory port owned by the stack sequencer.
// Master drives strobes/address/write data; memory returns read data same cycle.
interface stack_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_rd,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/stack_sequencer.sv
// Multi-cycle CALL/RET/RTI/INT/IRQ stack sequencer with its own stack pointer.
// Optional STACK_GUARD_EN adds stack_err and aborts over/underflowing accesses.
module stack_sequencer #(
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] SP_TOP     = 12'hFFF,
  parameter logic [31:0]       IRQ_VECTOR = 32'h0000_0002
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_call,
  input  logic              req_ret,
  input  logic              req_rti,
  input  logic              req_int,
  input  logic              irq,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       target_in,
  input  logic [2:0]        flags_in,
  stack_sequencer_if.master mem,
  output logic [ADDR_W-1:0] sp,
  output logic              stall,
  output logic              pc_load,
  output logic [31:0]       pc_out,
  output logic              flags_load,
  output logic [2:0]        flags_out
`ifdef STACK_GUARD_EN
  ,
  output logic              stack_err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    PSH_FLG,
    PSH_HI,
    PSH_LO,
    POP_LO,
    POP_HI,
    POP_FLG,
    FINISH
  } state_t;

  state_t            state_q, state_d, nxt;
  logic [ADDR_W-1:0] sp_q, sp_d, sp_inc;
  logic              pend_q, pend_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       tgt_q, tgt_d;
  logic [2:0]        flg_q, flg_d;
  logic [2:0]        fout_q, fout_d;
  logic              rti_q, rti_d;
  logic              push, pop, abort, start;
  logic [15:0]       wdat;

  assign sp_inc    = sp_q + ADDR_W'(1);
  assign sp        = sp_q;
  assign pc_out    = tgt_q;
  assign flags_out = fout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sp_q    <= SP_TOP;
      pend_q  <= 1'b0;
      pc_q    <= '0;
      tgt_q   <= '0;
      flg_q   <= '0;
      fout_q  <= '0;
      rti_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      flg_q   <= flg_d;
      fout_q  <= fout_d;
      rti_q   <= rti_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    pend_d        = pend_q | irq;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    flg_d         = flg_q;
    fout_d        = fout_q;
    rti_d         = rti_q;
    nxt           = state_q;
    push          = 1'b0;
    pop           = 1'b0;
    wdat          = '0;
    start         = req_rti | req_ret | req_call
                  | req_int | pend_q;
    stall         = (state_q != IDLE);
    pc_load       = 1'b0;
    flags_load    = 1'b0;
    mem.mem_rd    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          stall = 1'b1;
          pc_d  = pc_in;
          flg_d = flags_in;
          tgt_d = target_in;
          rti_d = 1'b0;
          priority case (1'b1)
            req_rti: begin
              rti_d   = 1'b1;
              state_d = POP_LO;
            end
            req_ret:  state_d = POP_LO;
            req_call: state_d = PSH_HI;
            req_int:  state_d = PSH_FLG;
            default: begin
              tgt_d   = IRQ_VECTOR;
              pend_d  = 1'b0;
              state_d = PSH_FLG;
            end
          endcase
        end
      end
      PSH_FLG: begin
        push = 1'b1;
        wdat = {13'b0, flg_q};
        nxt  = PSH_HI;
      end
      PSH_HI: begin
        push = 1'b1;
        wdat = pc_q[31:16];
        nxt  = PSH_LO;
      end
      PSH_LO: begin
        push = 1'b1;
        wdat = pc_q[15:0];
        nxt  = FINISH;
      end
      POP_LO: begin
        pop = 1'b1;
        nxt = POP_HI;
      end
      POP_HI: begin
        pop = 1'b1;
        nxt = rti_q ? POP_FLG : FINISH;
      end
      POP_FLG: begin
        pop = 1'b1;
        nxt = FINISH;
      end
      FINISH: begin
        pc_load    = 1'b1;
        flags_load = rti_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef STACK_GUARD_EN
    abort = (push & (sp_q == '0))
          | (pop & (sp_q == SP_TOP));
`else
    abort = 1'b0;
`endif

    // An aborted access leaves sp and memory untouched.
    if (abort) begin
      state_d = IDLE;
    end else if (push) begin
      mem.mem_wr    = 1'b1;
      mem.mem_addr  = sp_q;
      mem.mem_wdata = wdat;
      sp_d          = sp_q - ADDR_W'(1);
      state_d       = nxt;
    end else if (pop) begin
      mem.mem_rd   = 1'b1;
      mem.mem_addr = sp_inc;
      sp_d         = sp_inc;
      state_d      = nxt;
      case (state_q)
        POP_LO:  tgt_d[15:0]  = mem.mem_rdata;
        POP_HI:  tgt_d[31:16] = mem.mem_rdata;
        POP_FLG: fout_d       = mem.mem_rdata[2:0];
        default: ;
      endcase
    end
  end

`ifdef STACK_GUARD_EN
  assign stack_err = abort;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed table-driven bench for stack_sequencer with a small memory model.
// Hand sequences cover mid-sequence reset and empty-stack pop behaviour.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_call, req_ret, req_rti, req_int, irq;
  logic [31:0] pc_in, target_in;
  logic [2:0]  flags_in;
  logic [11:0] sp;
  logic        stall, pc_load, flags_load;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;
`ifdef STACK_GUARD_EN
  logic        stack_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] tbmem [4096];

  stack_sequencer_if #(.ADDR_W(12)) bus ();

  stack_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_call   (req_call),
    .req_ret    (req_ret),
    .req_rti    (req_rti),
    .req_int    (req_int),
    .irq        (irq),
    .pc_in      (pc_in),
    .target_in  (target_in),
    .flags_in   (flags_in),
    .mem        (bus),
    .sp         (sp),
    .stall      (stall),
    .pc_load    (pc_load),
    .pc_out     (pc_out),
    .flags_load (flags_load),
    .flags_out  (flags_out)
`ifdef STACK_GUARD_EN
    ,
    .stack_err  (stack_err)
`endif
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = bus.mem_rd ? tbmem[bus.mem_addr] : 16'h0;

  always @(posedge clk) begin
    if (bus.mem_wr) tbmem[bus.mem_addr] <= bus.mem_wdata;
  end

  typedef struct {
    logic [3:0]  req;   // {rti,ret,call,int}
    logic        irq;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [2:0]  flg;
    logic        stall;
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [15:0] wd;
    logic        pcl;
    logic [31:0] pco;
    logic        fl;
    logic [2:0]  flo;
    logic [11:0] sp;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic [3:0]  req,
    input logic        iq,
    input logic [31:0] pc,
    input logic [31:0] tg,
    input logic [2:0]  fg,
    input logic        st,
    input logic        rd,
    input logic        wr,
    input logic [11:0] ad,
    input logic [15:0] wd,
    input logic        pcl,
    input logic [31:0] pco,
    input logic        fl,
    input logic [2:0]  flo,
    input logic [11:0] s
  );
    vec_t v;
    v.req = req; v.irq = iq; v.pc = pc;
    v.tgt = tg; v.flg = fg; v.stall = st;
    v.rd = rd; v.wr = wr; v.addr = ad;
    v.wd = wd; v.pcl = pcl; v.pco = pco;
    v.fl = fl; v.flo = flo; v.sp = s;
    return v;
  endfunction

  task automatic drive(input logic [3:0] r, input logic iq);
    req_rti  = r[3];
    req_ret  = r[2];
    req_call = r[1];
    req_int  = r[0];
    irq      = iq;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic ok,
                     input string got, input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %s want %s", name, got, want);
    end
  endtask

  initial begin
    logic ok;
    logic pcl_seen;
    for (int i = 0; i < 4096; i++) tbmem[i] = 16'h0;
    tbmem[0] = 16'hBEEF;
    tbmem[1] = 16'h00AB;
    rst = 1'b1;
    drive(4'b0000, 1'b0);
    pc_in = '0;
    target_in = '0;
    flags_in = '0;

    //            req     irq pc            tgt           flg
    //            st rd wr addr    wd       pcl pco          fl flo    sp
    tbl[0]  = mk(4'b0010, 0, 32'h0001_0020, 32'h0000_0100, 3'b000,
                 1, 0, 0, 12'h000, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFF);
    tbl[1]  = mk(4'b0000, 0, 32'hDEAD_BEEF, 32'hCAFE_0000, 3'b111,
                 1, 0, 1, 12'hFFF, 16'h0001, 0, 32'h0, 0, 3'b0, 12'hFFF);
    tbl[2]  = mk(4'b0000, 0, 32'hDEAD_BEEF, 32'hCAFE_0000, 3'b111,
                 1, 0, 1, 12'hFFE, 16'h0020, 0, 32'h0, 0, 3'b0, 12'hFFE);
    tbl[3]  = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 0, 12'h000, 16'h0000, 1, 32'h0000_0100, 0, 3'b0, 12'hFFD);
    tbl[4]  = mk(4'b0100, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 0, 12'h000, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFD);
    tbl[5]  = mk(4'b0010, 0, 32'h0, 32'h0, 3'b000,
                 1, 1, 0, 12'hFFE, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFD);
    tbl[6]  = mk(4'b0000, 1, 32'h0, 32'h0, 3'b000,
                 1, 1, 0, 12'hFFF, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFE);
    tbl[7]  = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 0, 12'h000, 16'h0000, 1, 32'h0001_0020, 0, 3'b0, 12'hFFF);
    tbl[8]  = mk(4'b0000, 0, 32'h0000_0040, 32'h0000_9999, 3'b101,
                 1, 0, 0, 12'h000, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFF);
    tbl[9]  = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 1, 12'hFFF, 16'h0005, 0, 32'h0, 0, 3'b0, 12'hFFF);
    tbl[10] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 1, 12'hFFE, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFE);
    tbl[11] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 1, 12'hFFD, 16'h0040, 0, 32'h0, 0, 3'b0, 12'hFFD);
    tbl[12] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 0, 12'h000, 16'h0000, 1, 32'h0000_0002, 0, 3'b0, 12'hFFC);
    tbl[13] = mk(4'b1010, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 0, 12'h000, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFC);
    tbl[14] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 1, 0, 12'hFFD, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFC);
    tbl[15] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 1, 0, 12'hFFE, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFD);
    tbl[16] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 1, 0, 12'hFFF, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFE);
    tbl[17] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 0, 12'h000, 16'h0000, 1, 32'h0000_0040, 1, 3'b101, 12'hFFF);
    tbl[18] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 0, 0, 0, 12'h000, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFF);
    tbl[19] = mk(4'b0001, 0, 32'h1234_5678, 32'h0000_0200, 3'b010,
                 1, 0, 0, 12'h000, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFF);
    tbl[20] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 1, 12'hFFF, 16'h0002, 0, 32'h0, 0, 3'b0, 12'hFFF);
    tbl[21] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 1, 12'hFFE, 16'h1234, 0, 32'h0, 0, 3'b0, 12'hFFE);
    tbl[22] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 1, 12'hFFD, 16'h5678, 0, 32'h0, 0, 3'b0, 12'hFFD);
    tbl[23] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 0, 12'h000, 16'h0000, 1, 32'h0000_0200, 0, 3'b0, 12'hFFC);
    tbl[24] = mk(4'b0100, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 0, 12'h000, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFC);
    tbl[25] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 1, 0, 12'hFFD, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFC);
    tbl[26] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 1, 0, 12'hFFE, 16'h0000, 0, 32'h0, 0, 3'b0, 12'hFFD);
    tbl[27] = mk(4'b0000, 0, 32'h0, 32'h0, 3'b000,
                 1, 0, 0, 12'h000, 16'h0000, 1, 32'h1234_5678, 0, 3'b0, 12'hFFE);

    do_reset();
    #1;
    ok = !stall && !pc_load && !flags_load && sp == 12'hFFF
      && !bus.mem_rd && !bus.mem_wr
      && pc_out == 32'h0 && flags_out == 3'b0;
    chk("reset", ok,
        $sformatf("stall=%b pcl=%b fl=%b sp=%h pc=%h", stall, pc_load, flags_load, sp, pc_out),
        "stall=0 pcl=0 fl=0 sp=fff pc=00000000");

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].irq);
      pc_in     = tbl[i].pc;
      target_in = tbl[i].tgt;
      flags_in  = tbl[i].flg;
      #1;
      ok = stall == tbl[i].stall && bus.mem_rd == tbl[i].rd
        && bus.mem_wr == tbl[i].wr && pc_load == tbl[i].pcl
        && flags_load == tbl[i].fl && sp == tbl[i].sp;
      if (tbl[i].rd || tbl[i].wr) ok = ok && bus.mem_addr == tbl[i].addr;
      if (tbl[i].wr) ok = ok && bus.mem_wdata == tbl[i].wd;
      if (tbl[i].pcl) ok = ok && pc_out == tbl[i].pco;
      if (tbl[i].fl) ok = ok && flags_out == tbl[i].flo;
      chk($sformatf("row%0d", i), ok,
          $sformatf("st=%b rd=%b wr=%b a=%h wd=%h pcl=%b pc=%h fl=%b f=%b sp=%h",
                    stall, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
                    pc_load, pc_out, flags_load, flags_out, sp),
          $sformatf("st=%b rd=%b wr=%b a=%h wd=%h pcl=%b pc=%h fl=%b f=%b sp=%h",
                    tbl[i].stall, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd,
                    tbl[i].pcl, tbl[i].pco, tbl[i].fl, tbl[i].flo, tbl[i].sp));
    end

    // Reset two cycles into a software INT.
    do_reset();
    drive(4'b0001, 1'b0);
    pc_in     = 32'h0000_0777;
    target_in = 32'h0000_0300;
    flags_in  = 3'b110;
    @(negedge clk);
    drive(4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_int", !stall && sp == 12'hFFF && !pc_load,
        $sformatf("stall=%b sp=%h pcl=%b", stall, sp, pc_load),
        "stall=0 sp=fff pcl=0");
    pcl_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      pcl_seen = pcl_seen | pc_load | stall;
    end
    chk("rst_no_pcload", !pcl_seen,
        $sformatf("pcl_or_stall=%b", pcl_seen), "pcl_or_stall=0");
    chk("rst_mem_kept", tbmem[12'hFFF] == 16'h0006,
        $sformatf("%h", tbmem[12'hFFF]), "0006");

    // RET from an empty stack.
    @(negedge clk);
    drive(4'b0100, 1'b0);
    #1;
    chk("empty_ret_T", stall && sp == 12'hFFF,
        $sformatf("stall=%b sp=%h", stall, sp), "stall=1 sp=fff");
    @(negedge clk);
    drive(4'b0000, 1'b0);
    #1;
`ifdef STACK_GUARD_EN
    chk("guard_err", stack_err && !bus.mem_rd && !pc_load && sp == 12'hFFF,
        $sformatf("err=%b rd=%b pcl=%b sp=%h", stack_err, bus.mem_rd, pc_load, sp),
        "err=1 rd=0 pcl=0 sp=fff");
    @(negedge clk);
    #1;
    chk("guard_idle", !stack_err && !stall && !pc_load && sp == 12'hFFF,
        $sformatf("err=%b stall=%b pcl=%b sp=%h", stack_err, stall, pc_load, sp),
        "err=0 stall=0 pcl=0 sp=fff");
`else
    chk("wrap_lo", bus.mem_rd && bus.mem_addr == 12'h000 && sp == 12'hFFF,
        $sformatf("rd=%b a=%h sp=%h", bus.mem_rd, bus.mem_addr, sp),
        "rd=1 a=000 sp=fff");
    @(negedge clk);
    #1;
    chk("wrap_hi", bus.mem_rd && bus.mem_addr == 12'h001 && sp == 12'h000,
        $sformatf("rd=%b a=%h sp=%h", bus.mem_rd, bus.mem_addr, sp),
        "rd=1 a=001 sp=000");
    @(negedge clk);
    #1;
    chk("wrap_fin", pc_load && pc_out == 32'h00AB_BEEF && sp == 12'h001,
        $sformatf("pcl=%b pc=%h sp=%h", pc_load, pc_out, sp),
        "pcl=1 pc=00abbeef sp=001");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
